// File: rtl/sdrc_app_monitor.sv
// Passive checker for the SDRAM controller application interface: counts traffic, flags protocol errors.
// Optional SDRC_MON_LATENCY_EN adds rd_lat_max (read accept to first read beat, in clocks).
module sdrc_app_monitor #(
  parameter int APP_AW    = 26,
  parameter int APP_DW    = 32,
  parameter int BL_W      = 9,
  parameter int RDQ_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         app_req,
  input  logic [APP_AW-1:0]            app_req_addr,
  input  logic [BL_W-1:0]              app_req_len,
  input  logic                         app_req_wr_n,
  input  logic                         app_req_ack,
  input  logic                         app_wr_next_req,
  input  logic                         app_last_wr,
  input  logic                         app_rd_valid,
  input  logic                         app_last_rd,
  input  logic                         mon_clr,
  output logic [CNT_W-1:0]             wr_txn_cnt,
  output logic [CNT_W-1:0]             rd_txn_cnt,
  output logic [CNT_W-1:0]             wr_beat_cnt,
  output logic [CNT_W-1:0]             rd_beat_cnt,
  output logic [$clog2(RDQ_DEPTH):0]   rd_outstanding,
  output logic                         wr_busy,
  output logic [7:0]                   err_vec,
`ifdef SDRC_MON_LATENCY_EN
  output logic [CNT_W-1:0]             rd_lat_max,
`endif
  output logic                         err_any
);
  localparam int QAW = $clog2(RDQ_DEPTH);

  typedef enum logic {W_IDLE, W_DATA} w_state_t;

  w_state_t          w_state, w_nxt;
  logic [BL_W-1:0]   wr_cnt, wr_cnt_nxt;
  logic              wr_final;
  logic              e2, e3, e5;

  logic              acc, wr_acc, rd_acc, len_nz;
  assign acc    = app_req & app_req_ack;
  assign wr_acc = acc & ~app_req_wr_n;
  assign rd_acc = acc & app_req_wr_n;
  assign len_nz = |app_req_len;

  always_comb begin
    w_nxt      = w_state;
    wr_cnt_nxt = wr_cnt;
    wr_final   = 1'b0;
    e2         = 1'b0;
    e3         = 1'b0;
    e5         = 1'b0;
    case (w_state)
      W_IDLE: begin
        e2 = app_wr_next_req;
        if (wr_acc && len_nz) begin
          w_nxt      = W_DATA;
          wr_cnt_nxt = app_req_len;
        end
      end
      W_DATA: begin
        if (app_wr_next_req) begin
          wr_final   = (wr_cnt == BL_W'(1));
          e3         = app_last_wr != wr_final;
          wr_cnt_nxt = wr_cnt - BL_W'(1);
          if (wr_final) w_nxt = W_IDLE;
        end
        // Only a write accept coinciding with the final beat may start the next burst.
        if (wr_acc) begin
          if (!wr_final) e5 = 1'b1;
          else if (len_nz) begin
            w_nxt      = W_DATA;
            wr_cnt_nxt = app_req_len;
          end
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  // Read-length FIFO; rd_done counts beats already returned for the head burst.
  logic [BL_W-1:0] mem_len [RDQ_DEPTH];
  logic [QAW:0]    wptr, rptr, q_cnt;
  logic [BL_W-1:0] rd_done, head_len;
  logic            q_empty, q_full, head_last, pop, push_req, push;
  logic            e0, e1, e4, e6, e7;

  assign q_cnt     = wptr - rptr;
  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == (QAW+1)'(RDQ_DEPTH));
  assign head_len  = mem_len[rptr[QAW-1:0]];
  assign head_last = (rd_done == head_len - BL_W'(1));
  assign pop       = app_rd_valid & ~q_empty & head_last;
  assign push_req  = rd_acc & len_nz;
  assign e0        = app_rd_valid & q_empty;
  assign e1        = app_rd_valid & ~q_empty & (app_last_rd != head_last);
  assign e4        = push_req & q_full & ~pop;
  assign push      = push_req & ~e4;
  assign e6        = acc & ~len_nz;

  // A pending (unacked) request must hold its command stable until accepted.
  logic              req_pend, p_wr_n;
  logic [APP_AW-1:0] p_addr;
  logic [BL_W-1:0]   p_len;
  assign e7 = req_pend & (~app_req | (app_req_addr != p_addr) |
                          (app_req_len != p_len) | (app_req_wr_n != p_wr_n));

  logic [7:0] err_nxt;
  assign err_nxt = (mon_clr ? 8'h00 : err_vec) | {e7, e6, e5, e4, e3, e2, e1, e0};

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc,
                                            input logic clr);
    if (clr)            return '0;
    else if (inc && ~&c) return c + CNT_W'(1);
    else                return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state     <= W_IDLE;
      wr_cnt      <= '0;
      wptr        <= '0;
      rptr        <= '0;
      rd_done     <= '0;
      req_pend    <= 1'b0;
      p_addr      <= '0;
      p_len       <= '0;
      p_wr_n      <= 1'b0;
      wr_txn_cnt  <= '0;
      rd_txn_cnt  <= '0;
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
      err_vec     <= '0;
      err_any     <= 1'b0;
    end else begin
      w_state     <= w_nxt;
      wr_cnt      <= wr_cnt_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        rd_done <= '0;
      end else if (app_rd_valid && !q_empty) begin
        rd_done <= rd_done + BL_W'(1);
      end
      req_pend    <= app_req & ~app_req_ack;
      p_addr      <= app_req_addr;
      p_len       <= app_req_len;
      p_wr_n      <= app_req_wr_n;
      wr_txn_cnt  <= bump(wr_txn_cnt, wr_acc, mon_clr);
      rd_txn_cnt  <= bump(rd_txn_cnt, rd_acc, mon_clr);
      wr_beat_cnt <= bump(wr_beat_cnt, app_wr_next_req, mon_clr);
      rd_beat_cnt <= bump(rd_beat_cnt, app_rd_valid, mon_clr);
      err_vec     <= err_nxt;
      err_any     <= |err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_len[wptr[QAW-1:0]] <= app_req_len;
  end

  assign rd_outstanding = q_cnt;
  assign wr_busy        = (w_state == W_DATA);

`ifdef SDRC_MON_LATENCY_EN
  // Per-entry saturating age; an entry's age reads N-1 on the Nth edge after its accept.
  logic [CNT_W-1:0] age [RDQ_DEPTH];
  logic [CNT_W-1:0] head_lat;
  assign head_lat = (&age[rptr[QAW-1:0]]) ? age[rptr[QAW-1:0]] : age[rptr[QAW-1:0]] + CNT_W'(1);

  always_ff @(posedge clk) begin
    for (int i = 0; i < RDQ_DEPTH; i++) begin
      if (push && wptr[QAW-1:0] == QAW'(i)) age[i] <= '0;
      else if (~&age[i])                    age[i] <= age[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                               rd_lat_max <= '0;
    else if (mon_clr)                                           rd_lat_max <= '0;
    else if (app_rd_valid && !q_empty && rd_done == '0 && head_lat > rd_lat_max) rd_lat_max <= head_lat;
  end
`endif
endmodule

// File: doc/sdrc_app_monitor.md
Name: sdrc_app_monitor

Overview:
- Synthesisable protocol monitor/checker for the SDRAM controller application-side interface; the parametrised successor to the passive whitebox probe.
- Instantiated alongside the controller core, observing app_* signals only (never drives them).
- Tracks write and read bursts, counts transactions and beats, and flags protocol violations in sticky error bits readable by the test environment.

Parameters:
- APP_AW, 26, application address width.
- APP_DW, 32, application data width.
- BL_W, 9, burst-length field width.
- RDQ_DEPTH, 4, outstanding read bursts tracked; power of two, >=2.
- CNT_W, 16, transaction/beat counter width.

Ports:
- clk  in  1  controller application clock
- reset_n  in  1  asynchronous active-low reset
- app_req  in  1  request valid
- app_req_addr  in  APP_AW  request address
- app_req_len  in  BL_W  burst length in APP_DW words
- app_req_wr_n  in  1  0=write, 1=read
- app_req_ack  in  1  request accepted
- app_wr_next_req  in  1  write beat consumed
- app_last_wr  in  1  last write beat
- app_rd_valid  in  1  read beat valid
- app_last_rd  in  1  last read beat
- mon_clr  in  1  synchronous clear of counters and errors
- wr_txn_cnt  out  CNT_W  accepted write requests
- rd_txn_cnt  out  CNT_W  accepted read requests
- wr_beat_cnt  out  CNT_W  write beats
- rd_beat_cnt  out  CNT_W  read beats
- rd_outstanding  out  $clog2(RDQ_DEPTH)+1  read bursts accepted, not yet completed
- wr_busy  out  1  write burst in progress
- err_vec  out  8  sticky error flags
- err_any  out  1  OR of err_vec, registered

Behaviour:
- Reset: all outputs 0; write FSM = W_IDLE; read queue empty.
- Accept event: app_req & app_req_ack on a rising clk. app_req_len latched that cycle.
- Write FSM:
  - W_IDLE -> W_DATA on a write accept with len!=0; beat counter loads len.
  - In W_DATA, each app_wr_next_req decrements the counter.
  - Final beat (counter==1) -> W_IDLE; app_last_wr must be 1 on it.
  - A write accept in the same cycle as the final beat is legal and re-enters W_DATA.
- Read queue: FIFO of lengths.
  - Push on read accept with len!=0.
  - Head beat counter decrements on app_rd_valid; pop on the head's final beat; app_last_rd must be 1 on it.
  - Push and pop in the same cycle are allowed, including when full.
- err_vec bits; each set one cycle after the offending edge and held:
  - [0] app_rd_valid with queue empty.
  - [1] app_last_rd mismatch: high on a non-final beat, or low on the final beat.
  - [2] app_wr_next_req in W_IDLE.
  - [3] app_last_wr mismatch.
  - [4] read accept while full without a simultaneous pop; push dropped.
  - [5] write accept in W_DATA other than on its final beat; new burst ignored.
  - [6] accept with len==0; not queued, txn counter still increments.
  - [7] app_req falls, or addr/len/wr_n change, while app_req=1 and ack=0.
- Counters increment by 1 per event and saturate at all-ones; no wrap.
- mon_clr clears counters and err_vec only; FSM and queue untouched. If an error occurs in the same cycle as mon_clr, the error bit is set (set wins).
- Mid-burst reset returns the block to the reset state immediately.

Optional Feature:
- Macro: SDRC_MON_LATENCY_EN.
- Defined:
  - Adds output rd_lat_max (CNT_W): maximum clocks from read accept to that burst's first app_rd_valid.
  - A per-queue-entry timestamp is stored.
  - Saturating; cleared by mon_clr and reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Write len=4 accepted, 4 wr_next_req pulses, last_wr on 4th -> wr_txn_cnt=1, wr_beat_cnt=4, wr_busy low the cycle after beat 4, err_vec=0.
- 3 back-to-back reads of len 2,1,8, data returned in order with correct last_rd -> rd_outstanding peaks at 3 and returns to 0, rd_beat_cnt=11, err_vec=0.
- 5 reads accepted with RDQ_DEPTH=4, no data returned -> err_vec[4]=1, rd_outstanding=4.
- app_rd_valid with no read outstanding -> err_vec=8'h01, err_any=1 next cycle; then mon_clr -> err_vec=0.
- Write len=2 with last_wr on beat 1 and absent on beat 2 -> err_vec[3]=1.
- app_req drops before ack, then a len=0 request is acked -> err_vec[7]=1 and err_vec[6]=1; SDRC_MON_LATENCY_EN build: read acked at t, first valid at t+7 -> rd_lat_max=7.
